fir_frame_collector: RTL

Receiving end of the FIR output stream: consumes `fir_valid`/`fir_d` samples and assembles them into 16-sample parallel frames for the FFT stage. A valid/ready handshake delivers each frame from a single output holding register. It sits between the FIR filter and the FFT inside the top-level FAS datapath. Partial frames are discarded when the stream breaks. Frames that arrive while the output is still occupied are dropped and flagged.

---
 rtl/fas_pkg.sv | 14 +
 rtl/fir_frame_collector.sv | 83 ++++++++
 2 files changed

// File: rtl/fas_pkg.sv
// Shared FAS datapath types: sample and frame shapes used by the FIR->FFT path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fas_pkg;

  localparam int SAMPLE_W    = 16;
  localparam int FRAME_LEN   = 16;
  localparam int FRAME_CNT_W = $clog2(FRAME_LEN);

  typedef logic [SAMPLE_W-1:0] sample_t;
  // Slot 0 (oldest sample) sits in the least significant bits.
  typedef sample_t [FRAME_LEN-1:0] frame_t;

endpackage

// File: rtl/fir_frame_collector.sv
// Purpose: gathers FRAME_LEN consecutive FIR samples into one parallel frame for the FFT.
// Latency: frame_valid rises right after the edge that captures the last sample of a frame.
// Backpressure: none toward the FIR; a frame completing while the output is still held
//   (and not being consumed that edge) is dropped and sets sticky overrun.
// Ports:
//   clk, rst       - rising-edge clock, asynchronous active-high reset
//   fir_valid/fir_d - incoming sample stream; a low fir_valid discards any partial frame
//   frame_valid/frame_ready/frame_data - output holding register with valid/ready handshake
//   frame_idx      - count of frames delivered to the output register (wraps)
//   overrun        - sticky flag: a completed frame was dropped
//   filling        - a partial frame is being held
module fir_frame_collector #(
  parameter int SAMPLE_W  = fas_pkg::SAMPLE_W,
  parameter int FRAME_LEN = fas_pkg::FRAME_LEN
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          fir_valid,
  input  logic [SAMPLE_W-1:0]           fir_d,
  input  logic                          frame_ready,
  output logic                          frame_valid,
  output logic [FRAME_LEN*SAMPLE_W-1:0] frame_data,
  output logic [7:0]                    frame_idx,
  output logic                          overrun,
  output logic                          filling
);

  localparam int CW = $clog2(FRAME_LEN);

  logic [CW-1:0]                       cnt;
  // Only FRAME_LEN-1 slots are stored: the final sample goes straight from fir_d
  // into the output register on the completion edge.
  logic [FRAME_LEN-2:0][SAMPLE_W-1:0]  cap;

  logic last;
  logic complete;
  logic out_free;
  logic consume;

  assign last     = (cnt == CW'(FRAME_LEN - 1));
  assign complete = fir_valid && last;
  assign consume  = frame_valid && frame_ready;
  // The held frame may be overwritten if it is empty or leaves on this same edge.
  assign out_free = !frame_valid || frame_ready;
  assign filling  = (cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      cap         <= '0;
      frame_valid <= 1'b0;
      frame_data  <= '0;
      frame_idx   <= '0;
      overrun     <= 1'b0;
    end else begin
      // Sample counter: any gap in the stream restarts the frame at slot 0.
      if (fir_valid) begin
        if (last) begin
          cnt <= '0;
        end else begin
          cap[cnt] <= fir_d;
          cnt      <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end

      // A load takes priority over a consume so back-to-back frames need no gap.
      if (complete && out_free) begin
        frame_data  <= {fir_d, cap};
        frame_valid <= 1'b1;
        frame_idx   <= frame_idx + 8'd1;
      end else if (consume) begin
        frame_valid <= 1'b0;
      end

      if (complete && !out_free) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule
